// File: rtl/mtm_alu_deserializer_if.sv
// rtl/mtm_alu_deserializer_if.sv - operand/opcode/error bundle handshake toward the ALU core
interface mtm_alu_deserializer_if;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [2:0]  out_op;
  logic [2:0]  out_err;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output out_a, out_b, out_op, out_err, out_valid,
    input  out_ready
  );

  modport slave (
    input  out_a, out_b, out_op, out_err, out_valid,
    output out_ready
  );
endinterface

// File: rtl/mtm_alu_deserializer.sv
// rtl/mtm_alu_deserializer.sv - serial packet deframer, CRC/count/opcode checker for the mtm_Alu
module mtm_alu_deserializer #(
  parameter int DATA_BYTES = 8,
  parameter int CRC_W      = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sin,
  output logic overrun,
  mtm_alu_deserializer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE_WAIT,
    IDLE,
    TYPE,
    PAYLOAD,
    STOP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       bit_cnt;
  logic             is_cmd;
  logic [7:0]       payload;
  logic [63:0]      data_sr;
  logic [3:0]       byte_cnt;
  logic [CRC_W-1:0] crc;
  logic             bad_seq;

  logic             data_done;
  logic             cmd_done;
  logic [2:0]       cmd_op;
  logic [CRC_W-1:0] crc_exp;
  logic             err_data;
  logic             err_crc;
  logic             err_op;

  // One step of the x^4+x+1 serial LFSR
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic d);
    logic fb;
    fb = c[3] ^ d;
    return {c[2], c[1], c[0] ^ fb, fb};
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE_WAIT: if (sin) state_nxt = IDLE;
      IDLE:      if (!sin) state_nxt = TYPE;
      TYPE:      state_nxt = PAYLOAD;
      PAYLOAD:   if (bit_cnt == 3'd7) state_nxt = STOP;
      STOP:      state_nxt = sin ? IDLE : IDLE_WAIT;
      default:   state_nxt = IDLE_WAIT;
    endcase
  end

  // Command evaluation: the CRC stream is closed with a constant 1 and the opcode
  always_comb begin
    data_done = (state == STOP) && sin && !is_cmd;
    cmd_done  = (state == STOP) && sin && is_cmd;
    cmd_op    = payload[6:4];
    crc_exp   = crc_step(crc_step(crc_step(crc_step(crc, 1'b1), cmd_op[2]), cmd_op[1]), cmd_op[0]);
    err_data  = bad_seq || (byte_cnt != 4'(DATA_BYTES));
    err_crc   = !err_data && (crc_exp != payload[CRC_W-1:0]);
    err_op    = !err_data && !err_crc && !(cmd_op inside {3'b000, 3'b001, 3'b100, 3'b101});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE_WAIT;
      bit_cnt       <= '0;
      is_cmd        <= 1'b0;
      payload       <= '0;
      data_sr       <= '0;
      byte_cnt      <= '0;
      crc           <= '0;
      bad_seq       <= 1'b0;
      bus.out_a     <= '0;
      bus.out_b     <= '0;
      bus.out_op    <= '0;
      bus.out_err   <= '0;
      bus.out_valid <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == TYPE) begin
        is_cmd  <= sin;
        bit_cnt <= '0;
      end

      if (state == PAYLOAD) begin
        payload <= {payload[6:0], sin};
        bit_cnt <= bit_cnt + 3'd1;
        if (!is_cmd && (byte_cnt < 4'(DATA_BYTES))) begin
          crc <= crc_step(crc, sin);
        end
      end

      if ((state == STOP) && !sin) begin
        bad_seq <= 1'b1;
      end

      if (data_done) begin
        data_sr <= {data_sr[55:0], payload};
        if (byte_cnt != 4'd15) begin
          byte_cnt <= byte_cnt + 4'd1;
        end
      end

      if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end

      // Reception state always restarts; the bundle only loads if the output slot is free
      if (cmd_done) begin
        byte_cnt <= '0;
        crc      <= '0;
        bad_seq  <= 1'b0;
        if (!bus.out_valid || bus.out_ready) begin
          bus.out_b     <= data_sr[63:32];
          bus.out_a     <= data_sr[31:0];
          bus.out_op    <= cmd_op;
          bus.out_err   <= {err_data, err_crc, err_op};
          bus.out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// tb/tb_mtm_alu_deserializer.sv - self-checking bench for the mtm_Alu serial deserializer
module tb_mtm_alu_deserializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sin = 1'b1;
  logic overrun;
  logic pre_stop_valid;
  int   n_cmp = 0;
  int   n_bad = 0;

  mtm_alu_deserializer_if bus ();

  mtm_alu_deserializer #(.DATA_BYTES(8), .CRC_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sin     (sin),
    .overrun (overrun),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // CRC as polynomial remainder of M(x)*x^4 mod (x^4+x+1), M = {B, A, 1, op}
  function automatic logic [3:0] ref_crc(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op);
    logic [71:0] r;
    r = {b, a, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--) begin
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  function automatic logic [2:0] ref_err(input int ndata, input int bad_idx, input logic [3:0] crc_xor,
                                         input logic [2:0] op);
    if (ndata != 8 || bad_idx >= 0) return 3'b100;
    if (crc_xor != 4'b0000) return 3'b010;
    if (!(op inside {3'b000, 3'b001, 3'b100, 3'b101})) return 3'b001;
    return 3'b000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every bit is driven at a negedge and sampled by the DUT at the following posedge
  task automatic send_bit(input logic b);
    sin = b;
    @(negedge clk);
  endtask

  task automatic send_packet(input logic cmd, input logic [7:0] pl, input logic stop);
    send_bit(1'b0);
    send_bit(cmd);
    for (int i = 7; i >= 0; i--) send_bit(pl[i]);
    if (cmd) pre_stop_valid = bus.out_valid;
    send_bit(stop);
  endtask

  task automatic send_frame(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                            input logic [3:0] crc_xor, input int ndata, input int bad_idx);
    logic [63:0] ba;
    logic [7:0]  byt;
    ba = {b, a};
    for (int i = 0; i < ndata; i++) begin
      if (i < 8) byt = ba[63 - 8 * i -: 8];
      else       byt = 8'($urandom);
      send_packet(1'b0, byt, i != bad_idx);
      if (i == bad_idx) send_bit(1'b1);
    end
    send_packet(1'b1, {1'b0, op, ref_crc(b, a, op) ^ crc_xor}, 1'b1);
  endtask

  // Full frame with out_ready=1: bundle one cycle after stop, valid gone one cycle later
  task automatic run_frame(input string tag, input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                           input logic [3:0] crc_xor, input int ndata, input int bad_idx);
    logic [2:0] e;
    e = ref_err(ndata, bad_idx, crc_xor, op);
    send_frame(b, a, op, crc_xor, ndata, bad_idx);
    chk({tag, "_prevalid"}, 64'(pre_stop_valid), 64'd0);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_op"}, 64'(bus.out_op), 64'(op));
    chk({tag, "_err"}, 64'(bus.out_err), 64'(e));
    if (ndata == 8 && bad_idx < 0) begin
      chk({tag, "_a"}, 64'(bus.out_a), 64'(a));
      chk({tag, "_b"}, 64'(bus.out_b), 64'(b));
    end
    send_bit(1'b1);
    chk({tag, "_drop"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, a1, b1;
    logic [2:0]  rop;
    logic [3:0]  rx;
    int          nd;

    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    sin = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_a", 64'(bus.out_a), 64'd0);
    chk("rst_b", 64'(bus.out_b), 64'd0);
    chk("rst_op_err", 64'({bus.out_op, bus.out_err}), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    send_bit(1'b1);

    run_frame("t1", 32'd3, 32'd5, 3'b100, 4'b0000, 8, -1);
    run_frame("t2_crc", 32'd3, 32'd5, 3'b100, 4'b0001, 8, -1);
    run_frame("t3_short", 32'h1234_5678, 32'h9abc_def0, 3'b000, 4'b0000, 7, -1);
    run_frame("t3_long", 32'h1234_5678, 32'h9abc_def0, 3'b001, 4'b0000, 9, -1);
    run_frame("t4_op", 32'hcafe_f00d, 32'h0bad_beef, 3'b011, 4'b0000, 8, -1);
    run_frame("t4_stop", 32'hcafe_f00d, 32'h0bad_beef, 3'b101, 4'b0000, 8, 1);
    run_frame("t4_clean", 32'hcafe_f00d, 32'h0bad_beef, 3'b101, 4'b0000, 8, -1);

    for (int k = 0; k < 8; k++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = 3'($urandom);
      rx  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      nd  = ($urandom_range(0, 4) == 0) ? $urandom_range(6, 10) : 8;
      run_frame($sformatf("rnd%0d", k), rb, ra, rop, rx, nd, -1);
    end

    a1 = $urandom;
    b1 = $urandom;
    bus.out_ready = 1'b0;
    send_frame(b1, a1, 3'b101, 4'b0000, 8, -1);
    send_frame(32'h0f0f_0f0f, 32'hf0f0_f0f0, 3'b000, 4'b0000, 8, -1);
    chk("t5_valid", 64'(bus.out_valid), 64'd1);
    chk("t5_a", 64'(bus.out_a), 64'(a1));
    chk("t5_b", 64'(bus.out_b), 64'(b1));
    chk("t5_op_err", 64'({bus.out_op, bus.out_err}), 64'({3'b101, 3'b000}));
    chk("t5_overrun", 64'(overrun), 64'd1);
    bus.out_ready = 1'b1;
    send_bit(1'b1);
    chk("t5_drop", 64'(bus.out_valid), 64'd0);
    send_bit(1'b1);
    chk("t5_stay_low", 64'(bus.out_valid), 64'd0);

    send_packet(1'b0, 8'h11, 1'b1);
    send_packet(1'b0, 8'h22, 1'b1);
    send_packet(1'b0, 8'h33, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst_n = 1'b0;
    send_bit(1'b0);
    rst_n = 1'b1;
    chk("t6_rst_a", 64'(bus.out_a), 64'd0);
    chk("t6_rst_b", 64'(bus.out_b), 64'd0);
    chk("t6_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_rst_overrun", 64'(overrun), 64'd0);
    for (int k = 0; k < 14; k++) begin
      send_bit(1'b0);
      chk("t6_no_start", 64'(bus.out_valid), 64'd0);
    end
    send_bit(1'b1);
    run_frame("t6", 32'h0000_0000, 32'hffff_ffff, 3'b000, 4'b0000, 8, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
